multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multicycle RV32I core. Decodes the latched instruction fields and sequences fetch, decode, address generation, memory access, execute and writeback over several cycles, driving the datapath mux selects, write enables, ALU control and the 2-bit `ImmSrc` code consumed by the immediate sign-extension unit. It handles a variable-latency memory via a ready handshake and traps on unsupported opcodes.

## Interface
- No parameters.
- `clk`  in  1  single core clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Op`  in  7  instruction opcode field, from the instruction register (IR).
- `Funct3`  in  3  IR[14:12].
- `Funct7b5`  in  1  IR[30].
- `Zero`  in  1  ALU zero flag.
- `MemReady`  in  1  memory completes the current access this cycle.
- `ImmSrc`  out  2  00 I-type, 01 S-type, 10 B-type.
- `ALUControl`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- `ALUSrcA`  out  2  00 PC, 01 OldPC, 10 rs1.
- `ALUSrcB`  out  2  00 rs2, 01 ImmExt, 10 constant 4.
- `ResultSrc`  out  2  00 ALUOut, 01 mem data, 10 ALUResult.
- `AdrSrc`  out  1  0 PC, 1 Result.
- `PCWrite`, `IRWrite`, `MemWrite`, `RegWrite`, `MemReq`  out  1 each  write enables and memory request.
- `Retire`  out  1  one-cycle pulse in the final cycle of each instruction.
- `Illegal`  out  1  high while in TRAP.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, TRAP.
- IDLE: the reset state. All outputs are 0. Goes to FETCH unconditionally.
- FETCH:
  - Outputs: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite and PCWrite assert only in the cycle MemReady=1.
  - Holds in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target). Next state by Op:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> BEQ.
  - any other Op -> TRAP.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Goes to MEMREAD if Op[5]=0, else MEMWRITE.
- MEMREAD: MemReq=1, AdrSrc=1. Holds until MemReady=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, Retire=1. Goes to FETCH.
- MEMWRITE: MemReq=1, AdrSrc=1. MemWrite=1 only while MemReady=1. Holds until MemReady=1, then goes to FETCH with Retire=1.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALU decode. Goes to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALU decode. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, Retire=1. Goes to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=Zero, Retire=1. Goes to FETCH.
- TRAP: all enables 0, Illegal=1. Stays in TRAP until reset.
- ImmSrc is a pure function of Op in every state: 0100011 -> 01, 1100011 -> 10, otherwise 00.
- ALU decode:
  - Funct3 000 -> sub only when Op[5]=1 and Funct7b5=1, else add.
  - Funct3 010 -> slt; 110 -> or; 111 -> and.
  - All other Funct3 values -> add.
- Mux selects not listed for a state are 00.

## Timing
- State register updates on the rising edge of `clk`. `rst_n` low forces IDLE asynchronously.
- Every output is combinational from the state plus inputs. In IDLE every output is 0.
- Cycle counts with MemReady tied high:
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R-type and I-type ALU: 4 cycles.
  - beq: 3 cycles.
- Each memory-wait cycle (MemReady=0) adds one cycle.
- Reset asserted mid-instruction aborts the instruction; no enable pulses after the asynchronous assertion.
- MemReady is ignored outside FETCH, MEMREAD and MEMWRITE.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - state encoding (4-bit);
  - opcode constants;
  - ImmSrc, ALUControl, ALUSrcA/B and ResultSrc code constants.
- Sub-module `alu_decoder` is combinational (ALUOp, Funct3, Funct7b5, Op[5] -> ALUControl). The FSM instantiates it once.

## Test plan
- Reset, then release with MemReady=1 and Op=0000011, Funct3=010 -> states IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite and Retire high in MEMWB; ImmSrc=00 throughout.
- Op=0100011 with MemReady low for 2 cycles in MEMWRITE -> MemWrite high only in the ready cycle; ImmSrc=01; Retire high once.
- Op=1100011, Zero=1 then repeat with Zero=0 -> ImmSrc=10 and ALUControl=001 in BEQ; PCWrite=1 for Zero=1 and 0 for Zero=0.
- Op=0110011 with Funct3/Funct7b5 = 000/1, 110/0, 010/0 -> ALUControl 001, 011, 101 in EXECR. Op=0010011 with Funct3=000, Funct7b5=1 -> 000.
- Op=1111111 -> TRAP; Illegal=1 and all enables 0 for 10 cycles. rst_n pulse -> back to IDLE.
- rst_n asserted in MEMREAD while MemReady=0 -> immediately IDLE with all outputs 0; restarts at FETCH after release.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes, datapath select codes.
// Pure declarations; no timing or flow control of its own.
package riscv_ctrl_pkg;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEMADR   = 4'd3;
  localparam logic [3:0] S_MEMREAD  = 4'd4;
  localparam logic [3:0] S_MEMWB    = 4'd5;
  localparam logic [3:0] S_MEMWRITE = 4'd6;
  localparam logic [3:0] S_EXECR    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_ALUWB    = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_DEC = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    if (op == OP_STORE)       return IMM_S;
    else if (op == OP_BRANCH) return IMM_B;
    else                      return IMM_I;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from ALUOp and instruction function fields.
// Latency: combinational; no flow control.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_op5,
  output logic [2:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_DEC: begin
        case (i_funct3)
          // Only R-type (Op[5]=1) uses Funct7b5 to select sub; addi ignores it.
          3'b000:  o_alu_control = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main multicycle RV32I control FSM; outputs combinational from state, 3-5 cycles per instruction.
// Memory backpressure: FETCH, MEMREAD and MEMWRITE hold until MemReady; unsupported opcodes trap until reset.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Op,
  input  logic [2:0] Funct3,
  input  logic       Funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       MemReq,
  output logic       Retire,
  output logic       Illegal
);

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic [1:0] w_alu_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct3      (Funct3),
    .i_funct7b5    (Funct7b5),
    .i_op5         (Op[5]),
    .o_alu_control (ALUControl)
  );

  assign ImmSrc = (r_state == S_IDLE) ? IMM_I : imm_src(Op);

  always_comb begin
    w_next_state = r_state;
    w_alu_op     = ALUOP_ADD;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RS2;
    ResultSrc    = RES_ALUOUT;
    AdrSrc       = 1'b0;
    PCWrite      = 1'b0;
    IRWrite      = 1'b0;
    MemWrite     = 1'b0;
    RegWrite     = 1'b0;
    MemReq       = 1'b0;
    Retire       = 1'b0;
    Illegal      = 1'b0;
    case (r_state)
      S_IDLE: w_next_state = S_FETCH;
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        if (MemReady) w_next_state = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target from OldPC while the opcode is decoded.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (Op)
          OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
          OP_RTYPE:          w_next_state = S_EXECR;
          OP_ITYPE:          w_next_state = S_EXECI;
          OP_BRANCH:         w_next_state = S_BEQ;
          default:           w_next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA      = SRCA_RS1;
        ALUSrcB      = SRCB_IMM;
        w_next_state = Op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        if (MemReady) w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc    = RES_MEMDATA;
        RegWrite     = 1'b1;
        Retire       = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = MemReady;
        Retire   = MemReady;
        if (MemReady) w_next_state = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA      = SRCA_RS1;
        w_alu_op     = ALUOP_DEC;
        w_next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA      = SRCA_RS1;
        ALUSrcB      = SRCB_IMM;
        w_alu_op     = ALUOP_DEC;
        w_next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite     = 1'b1;
        Retire       = 1'b1;
        w_next_state = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA      = SRCA_RS1;
        w_alu_op     = ALUOP_SUB;
        PCWrite      = Zero;
        Retire       = 1'b1;
        w_next_state = S_FETCH;
      end
      S_TRAP:  Illegal = 1'b1;
      default: w_next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, random instruction stream
// against a phase-list reference model, and hand-written trap/reset sequences.
module tb_multicycle_ctrl;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct packed {
    logic [1:0] imm;
    logic [2:0] aluc;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic       adr;
    logic       pcw;
    logic       irw;
    logic       mw;
    logic       rw;
    logic       mreq;
    logic       ret;
    logic       ill;
  } out_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       zero;
    logic       rdy;
    out_t       exp;
  } vec_t;

  typedef enum int {P_FETCH, P_DEC, P_MADR, P_MRD, P_MWB, P_MWR, P_EXR, P_EXI, P_AWB, P_BEQ} phase_t;

  logic       clk;
  logic       rst_n;
  logic [6:0] Op;
  logic [2:0] Funct3;
  logic       Funct7b5;
  logic       Zero;
  logic       MemReady;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       AdrSrc;
  logic       PCWrite;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       MemReq;
  logic       Retire;
  logic       Illegal;

  out_t act;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[$];

  multicycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Op         (Op),
    .Funct3     (Funct3),
    .Funct7b5   (Funct7b5),
    .Zero       (Zero),
    .MemReady   (MemReady),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .AdrSrc     (AdrSrc),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .MemReq     (MemReq),
    .Retire     (Retire),
    .Illegal    (Illegal)
  );

  assign act = {ImmSrc, ALUControl, ALUSrcA, ALUSrcB, ResultSrc,
                AdrSrc, PCWrite, IRWrite, MemWrite, RegWrite, MemReq, Retire, Illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t mk(int imm, int aluc, int sa, int sb, int res, int adr, int pcw,
                              int irw, int mw, int rw, int mreq, int ret, int ill);
    out_t o;
    o.imm  = imm[1:0];
    o.aluc = aluc[2:0];
    o.srca = sa[1:0];
    o.srcb = sb[1:0];
    o.res  = res[1:0];
    o.adr  = adr[0];
    o.pcw  = pcw[0];
    o.irw  = irw[0];
    o.mw   = mw[0];
    o.rw   = rw[0];
    o.mreq = mreq[0];
    o.ret  = ret[0];
    o.ill  = ill[0];
    return o;
  endfunction

  function automatic vec_t v(string nm, logic [6:0] op, logic [2:0] f3, logic f7,
                             logic z, logic r, out_t e);
    vec_t x;
    x.name = nm; x.op = op; x.f3 = f3; x.f7 = f7; x.zero = z; x.rdy = r; x.exp = e;
    return x;
  endfunction

  function automatic int imm_exp(logic [6:0] op);
    if (op == SW) return 1;
    if (op == BQ) return 2;
    return 0;
  endfunction

  function automatic int alu_exp(logic [6:0] op, logic [2:0] f3, logic f7);
    case (f3)
      3'd0:    return (op[5] && f7) ? 1 : 0;
      3'd2:    return 5;
      3'd6:    return 3;
      3'd7:    return 2;
      default: return 0;
    endcase
  endfunction

  // Expected outputs of one instruction phase, straight from the operation table.
  function automatic out_t exp_out(phase_t p, logic [6:0] op, logic [2:0] f3, logic f7,
                                   logic z, logic r);
    int im;
    int rd;
    im = imm_exp(op);
    rd = int'(r);
    case (p)
      P_FETCH: return mk(im, 0, 0, 2, 2, 0, rd, rd, 0, 0, 1, 0, 0);
      P_DEC:   return mk(im, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      P_MADR:  return mk(im, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      P_MRD:   return mk(im, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
      P_MWB:   return mk(im, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
      P_MWR:   return mk(im, 0, 0, 0, 0, 1, 0, 0, rd, 0, 1, rd, 0);
      P_EXR:   return mk(im, alu_exp(op, f3, f7), 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      P_EXI:   return mk(im, alu_exp(op, f3, f7), 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      P_AWB:   return mk(im, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      default: return mk(im, 1, 2, 0, 0, 0, int'(z), 0, 0, 0, 0, 1, 0);
    endcase
  endfunction

  task automatic check(string nm, out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (imm,aluc,srca,srcb,res,adr,pcw,irw,mw,rw,mreq,ret,ill)",
               nm, act, exp);
    end
  endtask

  // Entered at a falling edge; drives, samples mid-low-phase, returns at the next falling edge.
  task automatic cyc(string nm, logic [6:0] op, logic [2:0] f3, logic f7, logic z, logic r,
                     out_t exp);
    Op = op; Funct3 = f3; Funct7b5 = f7; Zero = z; MemReady = r;
    #2;
    check(nm, exp);
    @(negedge clk);
  endtask

  task automatic run_random(int n_instr);
    phase_t     ph[$];
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       r;
    int         stall;
    bit         done;
    for (int n = 0; n < n_instr; n++) begin
      f3 = 3'($urandom);
      f7 = 1'($urandom);
      case ($urandom_range(0, 4))
        0:       begin op = LW; ph = '{P_FETCH, P_DEC, P_MADR, P_MRD, P_MWB}; end
        1:       begin op = SW; ph = '{P_FETCH, P_DEC, P_MADR, P_MWR}; end
        2:       begin op = RT; ph = '{P_FETCH, P_DEC, P_EXR, P_AWB}; end
        3:       begin op = IT; ph = '{P_FETCH, P_DEC, P_EXI, P_AWB}; end
        default: begin op = BQ; ph = '{P_FETCH, P_DEC, P_BEQ}; end
      endcase
      for (int k = 0; k < ph.size(); k++) begin
        stall = 0;
        done  = 0;
        while (!done) begin
          r = (stall > 8) ? 1'b1 : ($urandom_range(0, 2) != 0);
          Op = op; Funct3 = f3; Funct7b5 = f7; Zero = 1'($urandom); MemReady = r;
          #2;
          check("random", exp_out(ph[k], op, f3, f7, Zero, r));
          @(negedge clk);
          if ((ph[k] == P_FETCH || ph[k] == P_MRD || ph[k] == P_MWR) && !r) stall++;
          else done = 1;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    out_t zero_o;
    out_t trap_o;
    zero_o = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    trap_o = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // lw, memory always ready; MemReady low where it must be ignored
    tbl.push_back(v("lw_idle",    LW, 3'd2, 1'b0, 1'b0, 1'b1, zero_o));
    tbl.push_back(v("lw_fetch",   LW, 3'd2, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 2, 2, 0, 1, 1, 0, 0, 1, 0, 0)));
    tbl.push_back(v("lw_decode",  LW, 3'd2, 1'b0, 1'b0, 1'b0, mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v("lw_memadr",  LW, 3'd2, 1'b0, 1'b0, 1'b0, mk(0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v("lw_memread", LW, 3'd2, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(v("lw_memwb",   LW, 3'd2, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0)));
    // sw with one fetch wait and two write waits
    tbl.push_back(v("sw_fetch_wait", SW, 3'd2, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 2, 2, 0, 0, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(v("sw_fetch",      SW, 3'd2, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 2, 2, 0, 1, 1, 0, 0, 1, 0, 0)));
    tbl.push_back(v("sw_decode",     SW, 3'd2, 1'b0, 1'b0, 1'b1, mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v("sw_memadr",     SW, 3'd2, 1'b0, 1'b0, 1'b1, mk(1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v("sw_wait1",      SW, 3'd2, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(v("sw_wait2",      SW, 3'd2, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(v("sw_memwrite",   SW, 3'd2, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 0)));
    // beq taken then not taken
    tbl.push_back(v("beq1_fetch",  BQ, 3'd0, 1'b0, 1'b1, 1'b1, mk(2, 0, 0, 2, 2, 0, 1, 1, 0, 0, 1, 0, 0)));
    tbl.push_back(v("beq1_decode", BQ, 3'd0, 1'b0, 1'b1, 1'b1, mk(2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v("beq1_exec",   BQ, 3'd0, 1'b0, 1'b1, 1'b1, mk(2, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(v("beq0_fetch",  BQ, 3'd0, 1'b0, 1'b0, 1'b1, mk(2, 0, 0, 2, 2, 0, 1, 1, 0, 0, 1, 0, 0)));
    tbl.push_back(v("beq0_decode", BQ, 3'd0, 1'b0, 1'b0, 1'b1, mk(2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v("beq0_exec",   BQ, 3'd0, 1'b0, 1'b0, 1'b1, mk(2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
    // R-type sub / or / slt, then addi with Funct7b5 set
    tbl.push_back(v("sub_fetch",  RT, 3'd0, 1'b1, 1'b0, 1'b1, mk(0, 0, 0, 2, 2, 0, 1, 1, 0, 0, 1, 0, 0)));
    tbl.push_back(v("sub_decode", RT, 3'd0, 1'b1, 1'b0, 1'b1, mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v("sub_execr",  RT, 3'd0, 1'b1, 1'b0, 1'b1, mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v("sub_aluwb",  RT, 3'd0, 1'b1, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0)));
    tbl.push_back(v("or_fetch",   RT, 3'd6, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 2, 2, 0, 1, 1, 0, 0, 1, 0, 0)));
    tbl.push_back(v("or_decode",  RT, 3'd6, 1'b0, 1'b0, 1'b1, mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v("or_execr",   RT, 3'd6, 1'b0, 1'b0, 1'b1, mk(0, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v("or_aluwb",   RT, 3'd6, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0)));
    tbl.push_back(v("slt_fetch",  RT, 3'd2, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 2, 2, 0, 1, 1, 0, 0, 1, 0, 0)));
    tbl.push_back(v("slt_decode", RT, 3'd2, 1'b0, 1'b0, 1'b1, mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v("slt_execr",  RT, 3'd2, 1'b0, 1'b0, 1'b1, mk(0, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v("slt_aluwb",  RT, 3'd2, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0)));
    tbl.push_back(v("addi_fetch", IT, 3'd0, 1'b1, 1'b0, 1'b1, mk(0, 0, 0, 2, 2, 0, 1, 1, 0, 0, 1, 0, 0)));
    tbl.push_back(v("addi_decode",IT, 3'd0, 1'b1, 1'b0, 1'b1, mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v("addi_execi", IT, 3'd0, 1'b1, 1'b0, 1'b1, mk(0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v("addi_aluwb", IT, 3'd0, 1'b1, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0)));

    rst_n = 1'b0; Op = LW; Funct3 = 3'd0; Funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
    @(negedge clk);
    #2;
    check("reset_state", zero_o);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i].name, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].zero, tbl[i].rdy, tbl[i].exp);

    run_random(60);

    // Unsupported opcode: trap holds regardless of MemReady until reset
    cyc("trap_fetch",  BAD, 3'd0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 2, 2, 0, 1, 1, 0, 0, 1, 0, 0));
    cyc("trap_decode", BAD, 3'd0, 1'b0, 1'b0, 1'b1, mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      cyc("trap_hold", BAD, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), trap_o);
    rst_n = 1'b0;
    #1;
    check("trap_reset", zero_o);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_trap_idle",  LW, 3'd2, 1'b0, 1'b0, 1'b1, zero_o);
    cyc("post_trap_fetch", LW, 3'd2, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 2, 2, 0, 1, 1, 0, 0, 1, 0, 0));
    cyc("abort_decode",    LW, 3'd2, 1'b0, 1'b0, 1'b1, mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("abort_memadr",    LW, 3'd2, 1'b0, 1'b0, 1'b1, mk(0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("abort_memread",   LW, 3'd2, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));

    // Reset asserted mid-cycle while MEMREAD still waits on memory
    MemReady = 1'b0;
    #2;
    check("abort_still_waiting", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_async", zero_o);
    MemReady = 1'b1;
    @(negedge clk);
    #2;
    check("abort_held", zero_o);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("restart_idle",  LW, 3'd2, 1'b0, 1'b0, 1'b1, zero_o);
    cyc("restart_fetch", LW, 3'd2, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 2, 2, 0, 1, 1, 0, 0, 1, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
